// File: rtl/vread_stream.sv
// vread_stream: burst-reads the databus into an external 2-port memory while streaming stored
// words onto out0 via a delayed two-level address generator. VREAD_STREAM_OUT_REG_EN adds an out0 register.
module vread_stream #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int PERIOD_W   = 14,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int DELAY_W    = 7,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  output logic                    done,
  output logic                    databus_valid_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic                    databus_ready_0,
  input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
  input  logic                    databus_last_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic                    ext_2p_write_0,
  output logic [ADDR_W-1:0]       ext_2p_addr_out_0,
  output logic [AXI_DATA_W-1:0]   ext_2p_data_out_0,
  output logic                    ext_2p_read_0,
  output logic [ADDR_W-1:0]       ext_2p_addr_in_0,
  input  logic [DATA_W-1:0]       ext_2p_data_in_0,
  output logic [DATA_W-1:0]       out0,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [LEN_W-1:0]        length,
  input  logic                    enabled,
  input  logic                    pingPong,
  input  logic [ADDR_W-1:0]       start,
  input  logic [ADDR_W-1:0]       incr,
  input  logic [PERIOD_W-1:0]     per,
  input  logic [ADDR_W-1:0]       iter,
  input  logic [ADDR_W-1:0]       shift,
  input  logic [DELAY_W-1:0]      delay0
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DONE} fill_st_t;
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN} strm_st_t;

  fill_st_t              fill_st_q, fill_st_d;
  strm_st_t              strm_st_q, strm_st_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_W-1:0]     wcnt_q, wcnt_d;
  logic                  pp_q, pp_d, ppen_q, ppen_d;
  logic [DELAY_W-1:0]    dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]     a_q, a_d, incr_q, incr_d, shift_q, shift_d, icnt_q, icnt_d;
  logic [PERIOD_W-1:0]   per_q, per_d, pcnt_q, pcnt_d;
  logic                  rd_q;
  logic [DATA_W-1:0]     out_q;
  logic                  beat, sread, fill_done, stream_done;

  assign beat  = (fill_st_q == F_REQ) && databus_ready_0;
  assign sread = (strm_st_q == S_RUN) && running;

  always_comb begin
    fill_st_d = fill_st_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    pp_d      = pp_q;
    ppen_d    = ppen_q;
    if (run) begin
      pp_d   = pingPong ? ~pp_q : 1'b0;
      ppen_d = pingPong;
      wcnt_d = '0;
      if (enabled && (length != '0)) begin
        fill_st_d = F_REQ;
        addr_d    = ext_addr;
        len_d     = length;
      end else begin
        fill_st_d = F_IDLE;
      end
    end else if (beat) begin
      wcnt_d = wcnt_q + ADDR_W'(1);
      if (databus_last_0) fill_st_d = F_DONE;
    end
  end

  always_comb begin
    strm_st_d = strm_st_q;
    dcnt_d    = dcnt_q;
    a_d       = a_q;
    incr_d    = incr_q;
    shift_d   = shift_q;
    per_d     = per_q;
    pcnt_d    = pcnt_q;
    icnt_d    = icnt_q;
    if (run) begin
      a_d     = start;
      incr_d  = incr;
      shift_d = shift;
      per_d   = per;
      pcnt_d  = per;
      icnt_d  = iter;
      dcnt_d  = delay0;
      if (delay0 != '0)                    strm_st_d = S_DELAY;
      else if (per == '0 || iter == '0)    strm_st_d = S_IDLE;
      else                                 strm_st_d = S_RUN;
    end else if (running) begin
      case (strm_st_q)
        S_DELAY: begin
          if (dcnt_q == DELAY_W'(1))
            strm_st_d = (per_q == '0 || icnt_q == '0) ? S_IDLE : S_RUN;
          else
            dcnt_d = dcnt_q - DELAY_W'(1);
        end
        S_RUN: begin
          // the shift rides on top of the period's final increment
          if (pcnt_q == PERIOD_W'(1)) begin
            pcnt_d = per_q;
            a_d    = a_q + incr_q + shift_q;
            if (icnt_q == ADDR_W'(1)) strm_st_d = S_IDLE;
            else                      icnt_d    = icnt_q - ADDR_W'(1);
          end else begin
            pcnt_d = pcnt_q - PERIOD_W'(1);
            a_d    = a_q + incr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_st_q <= F_IDLE;
      strm_st_q <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      pp_q      <= 1'b0;
      ppen_q    <= 1'b0;
      dcnt_q    <= '0;
      a_q       <= '0;
      incr_q    <= '0;
      shift_q   <= '0;
      per_q     <= '0;
      pcnt_q    <= '0;
      icnt_q    <= '0;
      rd_q      <= 1'b0;
      out_q     <= '0;
    end else begin
      fill_st_q <= fill_st_d;
      strm_st_q <= strm_st_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      pp_q      <= pp_d;
      ppen_q    <= ppen_d;
      dcnt_q    <= dcnt_d;
      a_q       <= a_d;
      incr_q    <= incr_d;
      shift_q   <= shift_d;
      per_q     <= per_d;
      pcnt_q    <= pcnt_d;
      icnt_q    <= icnt_d;
      rd_q      <= sread;
      if (rd_q) out_q <= ext_2p_data_in_0;
    end
  end

`ifdef VREAD_STREAM_OUT_REG_EN
  logic sidle_q;
  always_ff @(posedge clk) begin
    if (rst) sidle_q <= 1'b1;
    else     sidle_q <= (strm_st_q == S_IDLE);
  end
  assign out0        = out_q;
  assign stream_done = (strm_st_q == S_IDLE) && sidle_q;
`else
  assign out0        = rd_q ? ext_2p_data_in_0 : out_q;
  assign stream_done = (strm_st_q == S_IDLE);
`endif

  assign fill_done = (fill_st_q != F_REQ);
  assign done      = fill_done && stream_done;

  assign databus_valid_0 = (fill_st_q == F_REQ);
  assign databus_addr_0  = addr_q;
  assign databus_len_0   = len_q;
  assign databus_wdata_0 = '0;
  assign databus_wstrb_0 = '0;

  // ping-pong: fill owns bank pp, stream owns the opposite bank
  assign ext_2p_write_0    = beat;
  assign ext_2p_addr_out_0 = ppen_q ? {pp_q, wcnt_q[ADDR_W-2:0]} : wcnt_q;
  assign ext_2p_data_out_0 = databus_rdata_0;
  assign ext_2p_read_0     = sread;
  assign ext_2p_addr_in_0  = ppen_q ? {~pp_q, a_q[ADDR_W-2:0]} : a_q;

endmodule
